// File: rtl/w0rm_arb_pkg.sv
// Shared encodings for the W0RM memory arbiter: FSM states, grant owner and
// the round-robin pick used when both ports are pending.
package w0rm_arb_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_INST_WAIT = 2'd1;
    localparam logic [1:0] ST_DATA_WAIT = 2'd2;

    localparam logic [0:0] GRANT_INST = 1'b0;
    localparam logic [0:0] GRANT_DATA = 1'b1;

    // On a tie the port that did not win last time is chosen.
    function automatic logic [0:0] pick_grant(input logic       inst_req,
                                              input logic       data_req,
                                              input logic [0:0] last_grant);
        logic [0:0] sel;
        if (inst_req && !data_req) begin
            sel = GRANT_INST;
        end else if (data_req && !inst_req) begin
            sel = GRANT_DATA;
        end else begin
            sel = (last_grant == GRANT_DATA) ? GRANT_INST : GRANT_DATA;
        end
        return sel;
    endfunction

endpackage

// File: rtl/w0rm_arb_req_latch.sv
// One-deep request holding register. A new request is taken only when the
// slot is free or being cleared in the same cycle (set wins over clear).
module w0rm_arb_req_latch #(
    parameter int PAYLOAD_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set,
    input  logic                     clr,
    input  logic [PAYLOAD_WIDTH-1:0] req_payload,
    output logic                     pending,
    output logic [PAYLOAD_WIDTH-1:0] held_payload
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= 1'b0;
            held_payload <= '0;
        end else if (set && (!pending || clr)) begin
            pending      <= 1'b1;
            held_payload <= req_payload;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/w0rm_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the W0RM fetch and data
// ports. Optional WAIT-state timeout is enabled by defining W0RM_ARB_TIMEOUT_EN.
module w0rm_mem_arbiter
    import w0rm_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  core_clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic                  inst_valid_i,
    output logic [DATA_WIDTH-1:0] inst_data_o,
    output logic                  inst_valid_o,
    output logic                  inst_err_o,

    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_data_i,
    input  logic                  data_read_i,
    input  logic                  data_write_i,
    input  logic                  data_valid_i,
    output logic [DATA_WIDTH-1:0] data_data_o,
    output logic                  data_valid_o,
    output logic                  data_err_o,

    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_read_o,
    output logic                  bus_write_o,
    output logic                  bus_valid_o,
    input  logic [DATA_WIDTH-1:0] bus_data_i,
    input  logic                  bus_valid_i,

    output logic [1:0]            dbg_state,
    output logic [31:0]           dbg_wait_cnt
);

    // Handshake: every request and response is a single-cycle valid pulse with
    // no back-pressure; bus_valid_o is taken as accepted and answered by exactly
    // one bus_valid_i, which is only honoured while a transaction is in flight.

    localparam int DATA_PW = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]            state;
    logic [0:0]            last_grant;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  inst_pend;
    logic [ADDR_WIDTH-1:0] inst_pend_addr;
    logic                  data_pend;
    logic [DATA_PW-1:0]    data_pend_pl;

    logic                  inst_set;
    logic                  inst_clr;
    logic                  data_set;
    logic                  data_clr;

    logic                  inst_req;
    logic                  data_req;
    logic [ADDR_WIDTH-1:0] inst_eff_addr;
    logic [DATA_PW-1:0]    data_eff_pl;
    logic                  eff_read;
    logic                  eff_write;
    logic [DATA_WIDTH-1:0] eff_wdata;
    logic [ADDR_WIDTH-1:0] eff_addr;

    logic                  in_idle;
    logic [0:0]            grant_sel;
    logic                  grant_inst;
    logic                  grant_data;
    logic                  data_null;
    logic                  null_ack;
    logic                  tmo_hit;
    logic                  wait_end;

    w0rm_arb_req_latch #(
        .PAYLOAD_WIDTH (ADDR_WIDTH)
    ) u_inst_latch (
        .clk          (core_clk),
        .reset        (reset),
        .set          (inst_set),
        .clr          (inst_clr),
        .req_payload  (inst_addr_i),
        .pending      (inst_pend),
        .held_payload (inst_pend_addr)
    );

    w0rm_arb_req_latch #(
        .PAYLOAD_WIDTH (DATA_PW)
    ) u_data_latch (
        .clk          (core_clk),
        .reset        (reset),
        .set          (data_set),
        .clr          (data_clr),
        .req_payload  ({data_read_i, data_write_i, data_data_i, data_addr_i}),
        .pending      (data_pend),
        .held_payload (data_pend_pl)
    );

    // A request arriving this cycle is arbitrated immediately so the bus pulse
    // lands one cycle after the request pulse.
    assign inst_req      = inst_pend | inst_valid_i;
    assign data_req      = data_pend | data_valid_i;
    assign inst_eff_addr = inst_pend ? inst_pend_addr : inst_addr_i;
    assign data_eff_pl   = data_pend ? data_pend_pl
                                     : {data_read_i, data_write_i, data_data_i, data_addr_i};
    assign {eff_read, eff_write, eff_wdata, eff_addr} = data_eff_pl;

    assign in_idle    = (state == ST_IDLE);
    assign grant_sel  = pick_grant(inst_req, data_req, last_grant);
    assign grant_inst = in_idle && inst_req && (grant_sel == GRANT_INST);
    assign grant_data = in_idle && data_req && (grant_sel == GRANT_DATA);
    assign data_null  = !eff_read && !eff_write;
    assign null_ack   = grant_data && data_null;

`ifdef W0RM_ARB_TIMEOUT_EN
    assign tmo_hit = !in_idle && !bus_valid_i && (wait_cnt == TMO_LIMIT);
`else
    assign tmo_hit = 1'b0;
`endif

    assign wait_end = !in_idle && (bus_valid_i || tmo_hit);

    // A null request taken straight from the input is consumed on the spot and
    // must not be left behind in the latch.
    assign inst_set = inst_valid_i;
    assign inst_clr = (state == ST_INST_WAIT) && wait_end;
    assign data_set = data_valid_i && !(null_ack && !data_pend);
    assign data_clr = ((state == ST_DATA_WAIT) && wait_end) || (null_ack && data_pend);

    always_ff @(posedge core_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= GRANT_DATA;
            wait_cnt     <= '0;
            bus_addr_o   <= '0;
            bus_data_o   <= '0;
            bus_read_o   <= 1'b0;
            bus_write_o  <= 1'b0;
            bus_valid_o  <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_data_o  <= '0;
            data_valid_o <= 1'b0;
            data_data_o  <= '0;
        end else begin
            bus_valid_o  <= 1'b0;
            inst_valid_o <= 1'b0;
            data_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (grant_inst) begin
                        last_grant  <= GRANT_INST;
                        bus_valid_o <= 1'b1;
                        bus_addr_o  <= inst_eff_addr;
                        bus_data_o  <= '0;
                        bus_read_o  <= 1'b1;
                        bus_write_o <= 1'b0;
                        state       <= ST_INST_WAIT;
                    end else if (grant_data) begin
                        last_grant <= GRANT_DATA;
                        if (data_null) begin
                            data_valid_o <= 1'b1;
                        end else begin
                            bus_valid_o <= 1'b1;
                            bus_addr_o  <= eff_addr;
                            bus_data_o  <= eff_wdata;
                            bus_read_o  <= eff_read && !eff_write;
                            bus_write_o <= eff_write;
                            state       <= ST_DATA_WAIT;
                        end
                    end
                end
                ST_INST_WAIT, ST_DATA_WAIT: begin
                    if (wait_end) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                        if (state == ST_INST_WAIT) begin
                            inst_valid_o <= 1'b1;
                            inst_data_o  <= bus_valid_i ? bus_data_i : '0;
                        end else begin
                            data_valid_o <= 1'b1;
                            data_data_o  <= bus_valid_i ? bus_data_i : '0;
                        end
                    end else if (wait_cnt != TMO_LIMIT) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef W0RM_ARB_TIMEOUT_EN
    always_ff @(posedge core_clk) begin
        if (reset) begin
            inst_err_o <= 1'b0;
            data_err_o <= 1'b0;
        end else begin
            inst_err_o <= tmo_hit && (state == ST_INST_WAIT);
            data_err_o <= tmo_hit && (state == ST_DATA_WAIT);
        end
    end
`else
    assign inst_err_o = 1'b0;
    assign data_err_o = 1'b0;
`endif

    assign dbg_state    = state;
    assign dbg_wait_cnt = 32'(wait_cnt);

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// Directed bench for w0rm_mem_arbiter: expected bus requests and port
// responses (with their cycle) are queued by the driver and checked by a monitor.
module tb_w0rm_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          core_clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] inst_addr_i = '0;
    logic          inst_valid_i = 1'b0;
    logic [DW-1:0] inst_data_o;
    logic          inst_valid_o;
    logic          inst_err_o;
    logic [AW-1:0] data_addr_i = '0;
    logic [DW-1:0] data_data_i = '0;
    logic          data_read_i = 1'b0;
    logic          data_write_i = 1'b0;
    logic          data_valid_i = 1'b0;
    logic [DW-1:0] data_data_o;
    logic          data_valid_o;
    logic          data_err_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_data_o;
    logic          bus_read_o;
    logic          bus_write_o;
    logic          bus_valid_o;
    logic [DW-1:0] bus_data_i = '0;
    logic          bus_valid_i = 1'b0;
    logic [1:0]    dbg_state;
    logic [31:0]   dbg_wait_cnt;

    w0rm_mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .core_clk     (core_clk),
        .reset        (reset),
        .inst_addr_i  (inst_addr_i),
        .inst_valid_i (inst_valid_i),
        .inst_data_o  (inst_data_o),
        .inst_valid_o (inst_valid_o),
        .inst_err_o   (inst_err_o),
        .data_addr_i  (data_addr_i),
        .data_data_i  (data_data_i),
        .data_read_i  (data_read_i),
        .data_write_i (data_write_i),
        .data_valid_i (data_valid_i),
        .data_data_o  (data_data_o),
        .data_valid_o (data_valid_o),
        .data_err_o   (data_err_o),
        .bus_addr_o   (bus_addr_o),
        .bus_data_o   (bus_data_o),
        .bus_read_o   (bus_read_o),
        .bus_write_o  (bus_write_o),
        .bus_valid_o  (bus_valid_o),
        .bus_data_i   (bus_data_i),
        .bus_valid_i  (bus_valid_i),
        .dbg_state    (dbg_state),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 core_clk = ~core_clk;

    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0]   cyc;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } bus_exp_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic          chk_data;
        logic          err;
        logic [DW-1:0] data;
    } rsp_exp_t;

    bus_exp_t exp_bus_q[$];
    rsp_exp_t exp_inst_q[$];
    rsp_exp_t exp_data_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=pulse(%0h) required=no pulse (cycle %0d)", name, act, cyc);
    endtask

    bus_exp_t be;
    rsp_exp_t re;

    always @(negedge core_clk) begin
        if (bus_valid_o) begin
            if (exp_bus_q.size() == 0) begin
                unexpected("bus_unexpected", 64'(bus_addr_o));
            end else begin
                be = exp_bus_q.pop_front();
                check("bus_cycle", 64'(cyc), 64'(be.cyc));
                check("bus_read",  64'(bus_read_o), 64'(be.rd));
                check("bus_write", 64'(bus_write_o), 64'(be.wr));
                check("bus_addr",  64'(bus_addr_o), 64'(be.addr));
                check("bus_data",  64'(bus_data_o), 64'(be.data));
            end
        end
        if (inst_valid_o) begin
            if (exp_inst_q.size() == 0) begin
                unexpected("inst_rsp_unexpected", 64'(inst_data_o));
            end else begin
                re = exp_inst_q.pop_front();
                check("inst_rsp_cycle", 64'(cyc), 64'(re.cyc));
                check("inst_rsp_err",   64'(inst_err_o), 64'(re.err));
                if (re.chk_data) check("inst_rsp_data", 64'(inst_data_o), 64'(re.data));
            end
        end
        if (data_valid_o) begin
            if (exp_data_q.size() == 0) begin
                unexpected("data_rsp_unexpected", 64'(data_data_o));
            end else begin
                re = exp_data_q.pop_front();
                check("data_rsp_cycle", 64'(cyc), 64'(re.cyc));
                check("data_rsp_err",   64'(data_err_o), 64'(re.err));
                if (re.chk_data) check("data_rsp_data", 64'(data_data_o), 64'(re.data));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge core_clk);
        #1;
        inst_valid_i = 1'b0;
        data_valid_i = 1'b0;
        bus_valid_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic req_inst(input logic [AW-1:0] a);
        inst_addr_i  = a;
        inst_valid_i = 1'b1;
    endtask

    task automatic req_data(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        data_read_i  = rd;
        data_write_i = wr;
        data_addr_i  = a;
        data_data_i  = d;
        data_valid_i = 1'b1;
    endtask

    task automatic ack(input logic [DW-1:0] d);
        bus_data_i  = d;
        bus_valid_i = 1'b1;
    endtask

    task automatic push_bus(input int c, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_bus_q.push_back('{cyc: 32'(c), rd: rd, wr: wr, addr: a, data: d});
    endtask

    task automatic push_inst(input int c, input logic [DW-1:0] d);
        exp_inst_q.push_back('{cyc: 32'(c), chk_data: 1'b1, err: 1'b0, data: d});
    endtask

    task automatic push_data(input int c, input logic chk, input logic err, input logic [DW-1:0] d);
        exp_data_q.push_back('{cyc: 32'(c), chk_data: chk, err: err, data: d});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({inst_valid_o, inst_err_o, data_valid_o, data_err_o,
                                   bus_read_o, bus_write_o, bus_valid_o}), 64'd0);
        check({tag, "_inst_data"}, 64'(inst_data_o), 64'd0);
        check({tag, "_data_data"}, 64'(data_data_o), 64'd0);
        check({tag, "_bus_addr"},  64'(bus_addr_o), 64'd0);
        check({tag, "_bus_data"},  64'(bus_data_o), 64'd0);
        check({tag, "_state"},     64'(dbg_state), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge core_clk);
        check_zero(tag);
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    int n;

    initial begin
        do_reset("reset");

        // single inst read, two idle wait cycles before the ack
        next_cycle(); n = cyc;
        req_inst(32'h100);
        push_bus(n + 1, 1'b1, 1'b0, 32'h100, 32'h0);
        idle(3);
        ack(32'hDEADBEEF);
        push_inst(n + 4, 32'hDEADBEEF);
        idle(3);

        // tie after reset: inst first; inst re-requested in its completion cycle
        do_reset("reset2");
        next_cycle(); n = cyc;
        req_inst(32'h10);
        req_data(1'b1, 1'b0, 32'h20, 32'h0);
        push_bus(n + 1, 1'b1, 1'b0, 32'h10, 32'h0);
        idle(2);
        ack(32'h11);
        req_inst(32'h30);
        push_inst(n + 3, 32'h11);
        push_bus(n + 4, 1'b1, 1'b0, 32'h20, 32'h0);
        idle(3);
        ack(32'h22);
        push_data(n + 6, 1'b1, 1'b0, 32'h22);
        push_bus(n + 7, 1'b1, 1'b0, 32'h30, 32'h0);
        idle(3);
        ack(32'h33);
        push_inst(n + 9, 32'h33);
        idle(3);

        // fresh tie with inst granted last: data first
        next_cycle(); n = cyc;
        req_inst(32'h50);
        req_data(1'b1, 1'b0, 32'h60, 32'h0);
        push_bus(n + 1, 1'b1, 1'b0, 32'h60, 32'h0);
        idle(2);
        ack(32'h66);
        push_data(n + 3, 1'b1, 1'b0, 32'h66);
        push_bus(n + 4, 1'b1, 1'b0, 32'h50, 32'h0);
        idle(3);
        ack(32'h55);
        push_inst(n + 6, 32'h55);
        idle(3);

        // data write, then read+write issued as write with a zero-wait ack
        next_cycle(); n = cyc;
        req_data(1'b0, 1'b1, 32'h40, 32'h55AA);
        push_bus(n + 1, 1'b0, 1'b1, 32'h40, 32'h55AA);
        idle(2);
        ack(32'h1234);
        push_data(n + 3, 1'b1, 1'b0, 32'h1234);
        idle(3);
        next_cycle(); n = cyc;
        req_data(1'b1, 1'b1, 32'h44, 32'h77);
        push_bus(n + 1, 1'b0, 1'b1, 32'h44, 32'h77);
        next_cycle();
        ack(32'h9);
        push_data(n + 2, 1'b1, 1'b0, 32'h9);
        idle(3);

        // null data request: local ack, no bus pulse
        next_cycle(); n = cyc;
        req_data(1'b0, 1'b0, 32'h48, 32'h0);
        push_data(n + 1, 1'b0, 1'b0, 32'h0);
        idle(4);

        // duplicate inst pulse while pending is dropped
        next_cycle(); n = cyc;
        req_inst(32'h200);
        push_bus(n + 1, 1'b1, 1'b0, 32'h200, 32'h0);
        next_cycle();
        req_inst(32'h300);
        idle(2);
        ack(32'hA5);
        push_inst(n + 4, 32'hA5);
        idle(5);

        // reset while in DATA_WAIT, then a stray ack
        next_cycle(); n = cyc;
        req_data(1'b1, 1'b0, 32'h80, 32'h0);
        push_bus(n + 1, 1'b1, 1'b0, 32'h80, 32'h0);
        idle(2);
        reset = 1'b1;
        next_cycle();
        @(negedge core_clk);
        check_zero("mid_reset");
        next_cycle();
        reset = 1'b0;
        next_cycle();
        ack(32'hBAD);
        idle(3);
        @(negedge core_clk);
        check_zero("stray_ack");

`ifdef W0RM_ARB_TIMEOUT_EN
        // timeout with TIMEOUT_CYCLES=4, late ack ignored, then normal traffic
        next_cycle(); n = cyc;
        req_data(1'b1, 1'b0, 32'h90, 32'h0);
        push_bus(n + 1, 1'b1, 1'b0, 32'h90, 32'h0);
        push_data(n + 6, 1'b1, 1'b1, 32'h0);
        idle(8);
        ack(32'h77);
        idle(3);
        next_cycle(); n = cyc;
        req_inst(32'hC0);
        push_bus(n + 1, 1'b1, 1'b0, 32'hC0, 32'h0);
        next_cycle();
        ack(32'hC1);
        push_inst(n + 2, 32'hC1);
        idle(3);
`endif

        idle(4);
        check("exp_bus_drained",  64'(exp_bus_q.size()),  64'd0);
        check("exp_inst_drained", 64'(exp_inst_q.size()), 64'd0);
        check("exp_data_drained", 64'(exp_data_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog actual=still running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
